hamming_decoder: RTL and testbench
==================================

# hamming_decoder

Hamming(7,4) single-error-correcting decoder placed directly downstream of Frame_Finder. It takes the recovered payload bit stream (DATA_OUT, DATA_OUT_VALID, LOCK), aligns codewords to the frame payload, and corrects up to one bit error per codeword. It then writes the 4 data bits per codeword, serially, into the receive-side output FIFO. A 2-codeword buffer absorbs FIFO backpressure, and status counters report corrected errors and overflow.

## Interface
- PAYLOAD_LEN, 28: payload bits per frame; must be a multiple of 7.
- CNT_WIDTH, 16: width of ERR_COUNT and WORD_COUNT.
- CLK  in  1  system clock; all logic on rising edge.
- RESET  in  1  asynchronous, active-low reset (0 = reset).
- DATA_IN  in  1  payload bit from Frame_Finder DATA_OUT.
- DATA_IN_VALID  in  1  DATA_IN qualifier (Frame_Finder DATA_OUT_VALID).
- LOCK  in  1  Frame_Finder lock; codeword alignment is valid only while high.
- FIFO_OUT_DATA  out  1  decoded data bit to output FIFO din.
- FIFO_OUT_WE  out  1  output FIFO write enable.
- FIFO_OUT_FULL  in  1  output FIFO full.
- ERR_COUNT  out  CNT_WIDTH  codewords with nonzero syndrome; saturates at all-ones.
- WORD_COUNT  out  CNT_WIDTH  codewords decoded; wraps modulo 2^CNT_WIDTH.
- OVERFLOW  out  1  sticky; a decoded nibble was dropped because the buffer was full.

## Operation
- Codeword bit order on the wire is c1 first, c7 last: c1=p1, c2=p2, c3=d1, c4=p3, c5=d2, c6=d3, c7=d4.
- Syndrome bits:
  - s1 = c1^c3^c5^c7
  - s2 = c2^c3^c6^c7
  - s3 = c4^c5^c6^c7
  - S = {s3,s2,s1}. S≠0 flips bit cS before extraction, so parity-bit errors leave the data unchanged.
- Shift/bit counter (0..6) advances on each cycle where DATA_IN_VALID=1 and LOCK=1. When the count reaches 6 with a valid bit, the codeword is complete:
  - it is decoded, pushed as nibble {d1,d2,d3,d4} into the buffer, and the counter returns to 0;
  - WORD_COUNT increments;
  - ERR_COUNT increments if S≠0.
- LOCK=0: the counter is held at 0, any partial codeword is discarded, and DATA_IN is ignored. Buffered nibbles keep draining.
- Alignment relies on Frame_Finder emitting payload from a frame boundary after lock and on PAYLOAD_LEN%7==0.
- Buffer: FIFO of 2 nibbles plus a 2-bit read pointer within the head nibble.
  - Output order is d1,d2,d3,d4.
  - FIFO_OUT_WE = (buffer non-empty) & ~FIFO_OUT_FULL; this is combinational on FULL.
  - FIFO_OUT_DATA = current head bit.
  - The bit pointer advances only when WE=1. After d4 is written, the nibble pops.
- Push and pop in the same cycle are both honoured, and occupancy is unchanged.
- Push with occupancy 2 and no pop that cycle: the new nibble is dropped and OVERFLOW is set. The counters still update.
- FIFO_OUT_DATA may be any value when WE=0; benches must not check it then.

## Timing
- Reset values: FIFO_OUT_WE=0, FIFO_OUT_DATA=0, ERR_COUNT=0, WORD_COUNT=0, OVERFLOW=0. Buffer is empty and the bit counter is 0.
- Reset is asynchronous assert and synchronous deassert at the block boundary; mid-operation it clears everything immediately.
- Latency: when c7 is valid in cycle t, the nibble is in the buffer at the edge ending t. If the buffer was empty and FULL=0, d1 is written in cycle t+1 and d4 in t+4.
- Counters update at the edge ending cycle t.
- Throughput: 4 output writes per 7 valid input bits. With FULL=0 the buffer never exceeds 1 nibble under continuous input.
- FULL asserted: WE drops in the same cycle and the head bit is held. Writing resumes the cycle FULL deasserts.

## Test plan
- Clean codeword: data 1011 encoded as 0,1,1,0,0,1,1 with LOCK=1 and FULL=0 -> writes 1,0,1,1 in cycles t+1..t+4; ERR_COUNT=0, WORD_COUNT=1.
- Single data error: receive 0,1,1,0,1,1,1 (c5 flipped, S=5) -> writes 1,0,1,1; ERR_COUNT=1.
- Parity error sweep: flip each of c1, c2, c4 in turn on 1011 -> output 1011 each time; ERR_COUNT=3 after the sweep.
- Lock loss: LOCK drops after 3 bits of a codeword, then returns, then a clean codeword 0000 (all zeros) is sent -> exactly 4 zeros written; the partial codeword is not counted; WORD_COUNT=1.
- Backpressure/overflow: hold FULL=1 and send 3 clean codewords -> the first 2 nibbles are retained, OVERFLOW=1, WORD_COUNT=3. Release FULL -> exactly 8 bits written, in order.
- Full-chain regression: Data_Generator -> Hamming encoder -> Frame_Former -> Frame_Finder -> hamming_decoder with one random bit flipped per codeword -> decoded stream equals the generator bits after the lock-acquisition offset; ERR_COUNT equals WORD_COUNT.

Source files
------------

// File: rtl/hamming_decoder.sv
// Hamming(7,4) single-error-correcting decoder downstream of Frame_Finder.
// Collects 7-bit codewords while locked, corrects one bit, and streams nibbles out through a 2-deep buffer.
module hamming_decoder #(
    parameter int PAYLOAD_LEN = 28,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 DATA_IN,
    input  logic                 DATA_IN_VALID,
    input  logic                 LOCK,
    output logic                 FIFO_OUT_DATA,
    output logic                 FIFO_OUT_WE,
    input  logic                 FIFO_OUT_FULL,
    output logic [CNT_WIDTH-1:0] ERR_COUNT,
    output logic [CNT_WIDTH-1:0] WORD_COUNT,
    output logic                 OVERFLOW
);

    generate
        if (PAYLOAD_LEN % 7 != 0) begin : g_bad_payload_len
            $error("hamming_decoder: PAYLOAD_LEN must be a multiple of 7");
        end
    endgenerate

    logic [2:0] bit_cnt;
    logic [5:0] shift;        // shift[k-1] holds ck for k = 1..6
    logic       take;
    logic       complete;
    logic [6:0] cw;
    logic [2:0] syn;
    logic [6:0] fixed;
    logic [3:0] nibble;

    logic [3:0] slot0;
    logic [3:0] slot1;
    logic [1:0] occ;
    logic [1:0] bit_ptr;
    logic       pop;

    assign take     = DATA_IN_VALID & LOCK;
    assign complete = take & (bit_cnt == 3'd6);
    assign cw       = {DATA_IN, shift};

    always_comb begin
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        fixed  = cw;
        if (syn != 3'd0) begin
            fixed = cw ^ (7'd1 << (syn - 3'd1));
        end
        nibble = {fixed[2], fixed[4], fixed[5], fixed[6]};
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            bit_cnt <= '0;
            shift   <= '0;
        end else if (!LOCK) begin
            bit_cnt <= '0;
        end else if (take) begin
            if (complete) begin
                bit_cnt <= '0;
            end else begin
                shift[bit_cnt] <= DATA_IN;
                bit_cnt        <= bit_cnt + 3'd1;
            end
        end
    end

    assign FIFO_OUT_WE   = (occ != 2'd0) & ~FIFO_OUT_FULL;
    assign FIFO_OUT_DATA = (occ != 2'd0) & slot0[2'd3 - bit_ptr];
    assign pop           = FIFO_OUT_WE & (bit_ptr == 2'd3);

    // slot0 is always the head; a pop shifts slot1 forward, and a simultaneous
    // push lands in whichever slot is free after that shift.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            slot0    <= '0;
            slot1    <= '0;
            occ      <= '0;
            bit_ptr  <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (FIFO_OUT_WE) begin
                bit_ptr <= bit_ptr + 2'd1;
            end
            if (complete && !pop) begin
                case (occ)
                    2'd0: begin
                        slot0 <= nibble;
                        occ   <= 2'd1;
                    end
                    2'd1: begin
                        slot1 <= nibble;
                        occ   <= 2'd2;
                    end
                    default: OVERFLOW <= 1'b1;
                endcase
            end else if (!complete && pop) begin
                slot0 <= slot1;
                occ   <= occ - 2'd1;
            end else if (complete && pop) begin
                if (occ == 2'd1) begin
                    slot0 <= nibble;
                end else begin
                    slot0 <= slot1;
                    slot1 <= nibble;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ERR_COUNT  <= '0;
            WORD_COUNT <= '0;
        end else if (complete) begin
            WORD_COUNT <= WORD_COUNT + 1'b1;
            if (syn != 3'd0 && ERR_COUNT != '1) begin
                ERR_COUNT <= ERR_COUNT + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hamming_decoder.sv
// Self-checking bench for hamming_decoder: directed cases from the decoder's
// behaviour plus randomized single-bit-error traffic against a nibble-level model.
module tb_hamming_decoder;

    logic        CLK;
    logic        RESET;
    logic        DATA_IN;
    logic        DATA_IN_VALID;
    logic        LOCK;
    logic        FIFO_OUT_DATA;
    logic        FIFO_OUT_WE;
    logic        FIFO_OUT_FULL;
    logic [15:0] ERR_COUNT;
    logic [15:0] WORD_COUNT;
    logic        OVERFLOW;

    hamming_decoder #(
        .PAYLOAD_LEN(28),
        .CNT_WIDTH  (16)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .DATA_IN      (DATA_IN),
        .DATA_IN_VALID(DATA_IN_VALID),
        .LOCK         (LOCK),
        .FIFO_OUT_DATA(FIFO_OUT_DATA),
        .FIFO_OUT_WE  (FIFO_OUT_WE),
        .FIFO_OUT_FULL(FIFO_OUT_FULL),
        .ERR_COUNT    (ERR_COUNT),
        .WORD_COUNT   (WORD_COUNT),
        .OVERFLOW     (OVERFLOW)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int   cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Observed output writes, captured mid-cycle
    logic got_bits[$];
    int   got_cyc[$];
    int   we_while_full = 0;

    always @(negedge CLK) begin
        if (RESET && FIFO_OUT_WE) begin
            got_bits.push_back(FIFO_OUT_DATA);
            got_cyc.push_back(cyc);
            if (FIFO_OUT_FULL) we_while_full++;
        end
    end

    // Reference model state
    logic exp_bits[$];
    int   exp_word = 0;
    int   exp_err  = 0;
    int   checks   = 0;
    int   errors   = 0;
    int   last_t   = 0;
    bit   rand_full = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Hamming(7,4) encode in wire order: bit 6 = c1 ... bit 0 = c7
    function automatic logic [6:0] enc(input logic [3:0] n);
        logic d1, d2, d3, d4;
        d1 = n[3]; d2 = n[2]; d3 = n[1]; d4 = n[0];
        return {d1 ^ d2 ^ d4, d1 ^ d3 ^ d4, d1, d2 ^ d3 ^ d4, d2, d3, d4};
    endfunction

    task automatic cyc_set(input logic v, input logic d);
        @(posedge CLK);
        #1;
        DATA_IN_VALID = v;
        DATA_IN       = d;
        if (rand_full) FIFO_OUT_FULL = ((cyc % 7) < 2) && ($urandom_range(0, 1) == 1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc_set(1'b0, 1'b0);
    endtask

    // flip = k flips ck (1..7); 0 sends the codeword clean
    task automatic send_nib(input logic [3:0] n, input int flip, input int gap_max);
        logic [6:0] cw;
        int gap;
        cw = enc(n);
        if (flip != 0) cw[7 - flip] = ~cw[7 - flip];
        for (int i = 0; i < 7; i++) begin
            gap = $urandom_range(0, gap_max);
            for (int g = 0; g < gap; g++) cyc_set(1'b0, 1'($urandom_range(0, 1)));
            cyc_set(1'b1, cw[6 - i]);
        end
        last_t = cyc;
        cyc_set(1'b0, 1'b0);
        for (int j = 3; j >= 0; j--) exp_bits.push_back(n[j]);
        exp_word++;
        if (flip != 0) exp_err++;
    endtask

    task automatic drain_compare(input string name, input int budget);
        int n = 0;
        int m;
        while (got_bits.size() < exp_bits.size() && n < budget) begin
            cyc_set(1'b0, 1'b0);
            n++;
        end
        idle(6);
        chk($sformatf("%s_len", name), got_bits.size(), exp_bits.size());
        m = (got_bits.size() < exp_bits.size()) ? got_bits.size() : exp_bits.size();
        for (int i = 0; i < m; i++)
            chk($sformatf("%s_bit%0d", name, i), 32'(got_bits[i]), 32'(exp_bits[i]));
    endtask

    task automatic clear_q();
        got_bits.delete();
        got_cyc.delete();
        exp_bits.delete();
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        DATA_IN_VALID = 1'b0;
        DATA_IN = 1'b0;
        LOCK = 1'b1;
        FIFO_OUT_FULL = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        chk("rst_we", FIFO_OUT_WE, 0);
        chk("rst_data", FIFO_OUT_DATA, 0);
        chk("rst_err", ERR_COUNT, 0);
        chk("rst_word", WORD_COUNT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        RESET = 1'b1;
        clear_q();
        exp_word = 0;
        exp_err = 0;
        idle(2);
    endtask

    initial begin
        RESET = 1'b0;
        DATA_IN = 1'b0;
        DATA_IN_VALID = 1'b0;
        LOCK = 1'b1;
        FIFO_OUT_FULL = 1'b0;

        // Clean codeword 1011 with latency check
        do_reset();
        send_nib(4'b1011, 0, 0);
        drain_compare("clean", 40);
        if (got_cyc.size() >= 4) begin
            chk("clean_first_cyc", got_cyc[0], last_t + 1);
            chk("clean_last_cyc", got_cyc[3], last_t + 4);
        end else begin
            chk("clean_write_count", got_cyc.size(), 4);
        end
        chk("clean_err", ERR_COUNT, exp_err);
        chk("clean_word", WORD_COUNT, 1);
        clear_q();

        // Single data-bit error on c5
        send_nib(4'b1011, 5, 0);
        drain_compare("c5err", 40);
        chk("c5err_err", ERR_COUNT, 1);
        chk("c5err_word", WORD_COUNT, exp_word);
        clear_q();

        // Parity-bit error sweep
        do_reset();
        send_nib(4'b1011, 1, 0);
        send_nib(4'b1011, 2, 0);
        send_nib(4'b1011, 4, 0);
        drain_compare("parity", 80);
        chk("parity_err", ERR_COUNT, 3);
        chk("parity_word", WORD_COUNT, exp_word);
        clear_q();

        // Lock loss discards a partial codeword
        do_reset();
        for (int i = 0; i < 3; i++) cyc_set(1'b1, 1'b1);
        LOCK = 1'b0;
        for (int i = 0; i < 4; i++) cyc_set(1'b1, 1'($urandom_range(0, 1)));
        LOCK = 1'b1;
        send_nib(4'b0000, 0, 0);
        drain_compare("lock", 40);
        chk("lock_word", WORD_COUNT, 1);
        chk("lock_err", ERR_COUNT, 0);
        clear_q();

        // Backpressure: third nibble dropped, first two retained in order
        do_reset();
        FIFO_OUT_FULL = 1'b1;
        send_nib(4'($urandom_range(0, 15)), 0, 1);
        send_nib(4'($urandom_range(0, 15)), 0, 1);
        send_nib(4'($urandom_range(0, 15)), 0, 1);
        for (int j = 0; j < 4; j++) void'(exp_bits.pop_back());
        idle(3);
        chk("ovf_no_writes", got_bits.size(), 0);
        chk("ovf_flag", OVERFLOW, 1);
        chk("ovf_word", WORD_COUNT, 3);
        FIFO_OUT_FULL = 1'b0;
        drain_compare("ovf_drain", 40);
        chk("ovf_sticky", OVERFLOW, 1);
        clear_q();

        // Asynchronous reset mid-operation
        FIFO_OUT_FULL = 1'b1;
        send_nib(4'b0110, 0, 0);
        @(posedge CLK);
        #3;
        RESET = 1'b0;
        #1;
        chk("arst_word", WORD_COUNT, 0);
        chk("arst_ovf", OVERFLOW, 0);
        chk("arst_we", FIFO_OUT_WE, 0);

        // Randomized traffic with single-bit errors and sparse backpressure
        do_reset();
        rand_full = 1;
        for (int k = 0; k < 40; k++)
            send_nib(4'($urandom_range(0, 15)), $urandom_range(0, 7), 2);
        rand_full = 0;
        FIFO_OUT_FULL = 1'b0;
        drain_compare("rand", 200);
        chk("rand_err", ERR_COUNT, exp_err);
        chk("rand_word", WORD_COUNT, exp_word);
        chk("rand_ovf", OVERFLOW, 0);
        chk("we_while_full", we_while_full, 0);
        clear_q();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
